counter_switch_ctrl: RTL

COUNTER_SWITCH_CTRL -- requirements
Module: counter_switch_ctrl

---
 rtl/counter_switch_ctrl_pkg.sv | 13 +
 rtl/counter_switch_ctrl_debounce.sv | 63 ++++++
 rtl/counter_switch_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/counter_switch_ctrl_pkg.sv
// Shared constants for the run/pause/clear switch controller.
// State encodings are visible on o_State.
package counter_switch_ctrl_pkg;

  localparam int DEBOUNCE_LIMIT_DEF = 250_000;

  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_PAUSED  = 2'b01,
    ST_RUNNING = 2'b10
  } state_t;

endpackage

// File: rtl/counter_switch_ctrl_debounce.sv
// Two-flop synchronizer plus counting debouncer for one switch.
// o_Press is a registered one-cycle pulse on a debounced 0->1.
module switch_debounce
  import counter_switch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic          sync_1;
  logic          sync_2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Bring the raw switch into the clock domain.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= i_Switch;
      sync_2 <= sync_1;
    end
  end

  // Accept a new level only after it holds for the full limit.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync_2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Rising edge of the debounced level becomes a press pulse.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      stable_d <= 1'b0;
      o_Press  <= 1'b0;
    end else begin
      stable_d <= stable;
      o_Press  <= stable & ~stable_d;
    end
  end

  assign o_Switch = stable;

endmodule

// File: rtl/counter_switch_ctrl.sv
// Run/pause and clear control for a downstream 00-99 counter.
// Clear has priority over run/pause when both presses coincide.
module counter_switch_ctrl
  import counter_switch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  output logic       o_Run,
  output logic       o_Clear,
  output logic [1:0] o_State
);

  state_t state;
  state_t state_nx;
  logic   run_nx;
  logic   clear_nx;
  logic   sw1_lvl;
  logic   sw2_lvl;
  logic   sw1_press;
  logic   sw2_press;

  switch_debounce #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_sw1 (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch_1),
    .o_Switch(sw1_lvl),
    .o_Press (sw1_press)
  );

  switch_debounce #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_sw2 (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch_2),
    .o_Switch(sw2_lvl),
    .o_Press (sw2_press)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_nx = state;
    clear_nx = 1'b0;
    unique case (state)
      ST_INIT: begin
        state_nx = ST_PAUSED;
        clear_nx = 1'b1;
      end
      ST_PAUSED, ST_RUNNING: begin
        if (sw2_press) begin
          state_nx = ST_PAUSED;
          clear_nx = 1'b1;
        end else if (sw1_press) begin
          state_nx = (state == ST_PAUSED) ?
                     ST_RUNNING : ST_PAUSED;
        end
      end
      default: state_nx = ST_INIT;
    endcase
    run_nx = (state_nx == ST_RUNNING);
  end

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= ST_INIT;
      o_Run   <= 1'b0;
      o_Clear <= 1'b0;
    end else begin
      state   <= state_nx;
      o_Run   <= run_nx;
      o_Clear <= clear_nx;
    end
  end

  assign o_State = state;

endmodule
